// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm
// Brief    : Multi-cycle RV32I main control FSM. Each instruction is
//            sequenced through FETCH, DECODE, EXEC, optional MEM and WB.
//            The FSM drives the PC enable and next-PC select, IR load, ALU
//            operand and op selects, data-memory strobes and register-file
//            write. It also keeps a count of retired instructions.
//            All strobes are combinational from the state and the inputs,
//            and are forced low while reset is high.
// Config   : CTRL_ILLEGAL_HALT_EN - when defined, an unlisted opcode halts
//            the machine (HALT, illegal=1) until reset. When undefined, an
//            unlisted opcode retires as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_fsm #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [4:0]  rd,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_en,
  output logic        pc_en,
  output logic        pcjump,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t      r_state;
  logic [31:0] r_instret;

  logic w_is_op, w_is_imm, w_is_lui, w_is_auipc, w_is_jal, w_is_jalr;
  logic w_is_load, w_is_store, w_is_branch, w_is_nop;
  logic w_to_wb, w_known;
  logic w_unused;

  assign w_is_op     = (opcode == OPC_OP);
  assign w_is_imm    = (opcode == OPC_IMM);
  assign w_is_lui    = (opcode == OPC_LUI);
  assign w_is_auipc  = (opcode == OPC_AUIPC);
  assign w_is_jal    = (opcode == OPC_JAL);
  assign w_is_jalr   = (opcode == OPC_JALR);
  assign w_is_load   = (opcode == OPC_LOAD);
  assign w_is_store  = (opcode == OPC_STORE);
  assign w_is_branch = (opcode == OPC_BRANCH);
  assign w_is_nop    = (opcode == OPC_FENCE) || (opcode == OPC_SYSTEM);

  // Instructions that finish with a register writeback
  assign w_to_wb = w_is_op | w_is_imm | w_is_lui | w_is_auipc | w_is_jal | w_is_jalr;
  assign w_known = w_to_wb | w_is_load | w_is_store | w_is_branch | w_is_nop;

  // Only func7[5] (the alt bit) affects control
  assign w_unused = &{1'b0, func7[6], func7[4:0]};

  // Strobes and ALU selects decoded from the current state and the inputs
  always_comb begin
    imem_req  = 1'b0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    pcjump    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'b00;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = 4'b0000;

    // ALU selects stay valid from EXEC through WB, so the ALU result seen
    // by MEM addressing and WB (including the jump target) remains stable.
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      if (w_is_op) begin
        alu_op = {func7[5], func3};
      end else if (w_is_imm) begin
        alu_b_sel = 1'b1;
        alu_op    = {(func3 == 3'b101) & func7[5], func3};
      end else if (w_is_auipc | w_is_jal | w_is_branch) begin
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
      end else if (w_is_jalr | w_is_load | w_is_store) begin
        alu_b_sel = 1'b1;
      end
    end

    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_en    = imem_ready;
      end
      S_EXEC: begin
        if (w_is_branch) begin
          pc_en  = 1'b1;
          pcjump = branch_taken;
        end else if (w_is_nop) begin
          pc_en = 1'b1;
        end
`ifndef CTRL_ILLEGAL_HALT_EN
        else if (!w_known) begin
          pc_en = 1'b1;
        end
`endif
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_store;
        pc_en    = w_is_store & dmem_ready;
      end
      S_WB: begin
        reg_we = (rd != 5'd0);
        pc_en  = 1'b1;
        pcjump = w_is_jal | w_is_jalr;
        if (w_is_jal | w_is_jalr) wb_sel = 2'b10;
        else if (w_is_load)       wb_sel = 2'b01;
        else if (w_is_lui)        wb_sel = 2'b11;
      end
      default: ;
    endcase

    if (reset) begin
      imem_req  = 1'b0;
      ir_en     = 1'b0;
      pc_en     = 1'b0;
      pcjump    = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 2'b00;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = 4'b0000;
    end
  end

  // State sequencing and retired-instruction counting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= state_t'(RESET_STATE);
      r_instret <= 32'd0;
    end else begin
      if (pc_en) r_instret <= r_instret + 32'd1;
      case (r_state)
        S_FETCH:  if (imem_ready) r_state <= S_DECODE;
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (w_is_load | w_is_store) r_state <= S_MEM;
          else if (w_to_wb)          r_state <= S_WB;
`ifdef CTRL_ILLEGAL_HALT_EN
          else if (!w_known)         r_state <= S_HALT;
`endif
          else                       r_state <= S_FETCH;
        end
        S_MEM:    if (dmem_ready) r_state <= w_is_store ? S_FETCH : S_WB;
        S_WB:     r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

`ifdef CTRL_ILLEGAL_HALT_EN
  assign illegal = (r_state == S_HALT) && !reset;
`else
  assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_fsm
// Brief    : Randomized bench for ctrl_fsm. Each instruction is expanded by
//            a transaction-level model into its expected per-cycle phases
//            (fetch with waits, decode, execute, memory with waits, write-
//            back) and the expected strobes of each phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic        branch_taken, imem_ready, dmem_ready;
  logic        imem_req, ir_en, pc_en, pcjump, alu_a_sel, alu_b_sel;
  logic [3:0]  alu_op;
  logic        dmem_req, dmem_we, reg_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;
  logic        illegal;

  ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
    .rd(rd), .branch_taken(branch_taken), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_en(ir_en), .pc_en(pc_en),
    .pcjump(pcjump), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
    .wb_sel(wb_sel), .state(state), .instret(instret), .illegal(illegal)
  );

  typedef enum int {K_ALU, K_IMM, K_LUI, K_AUIPC, K_JAL, K_JALR,
                    K_LOAD, K_STORE, K_BR, K_NOP, K_ILL} kind_t;

`ifdef CTRL_ILLEGAL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_instret;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] op_of(input kind_t k, input bit alt);
    case (k)
      K_ALU:   return 7'b0110011;
      K_IMM:   return 7'b0010011;
      K_LUI:   return 7'b0110111;
      K_AUIPC: return 7'b0010111;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      K_LOAD:  return 7'b0000011;
      K_STORE: return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_NOP:   return alt ? 7'b1110011 : 7'b0001111;
      default: return 7'b1111111;
    endcase
  endfunction

  // {illegal, imem_req, ir_en, pc_en, pcjump, dmem_req, dmem_we, reg_we}
  function automatic logic [7:0] obs_vec();
    return {illegal, imem_req, ir_en, pc_en, pcjump, dmem_req, dmem_we, reg_we};
  endfunction

  task automatic noise();
    imem_ready = 1'($urandom_range(0, 1));
    dmem_ready = 1'($urandom_range(0, 1));
  endtask

  // Runs one instruction starting at a negedge in FETCH; ends at negedge+1
  task automatic run_instr(input kind_t k, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rdv, input logic bt,
                           input int iwait, input int dwait);
    logic       st, mem_k, wb_k, jmp, rdy, pce, chk_sel;
    logic [5:0] es;
    logic [1:0] ewb;
    opcode = op_of(k, 1'($urandom_range(0, 1)));
    func3 = f3; func7 = f7; rd = rdv; branch_taken = bt;
    st    = (k == K_STORE);
    mem_k = (k == K_LOAD) || st;
    wb_k  = (k inside {K_ALU, K_IMM, K_LUI, K_AUIPC, K_JAL, K_JALR, K_LOAD});
    jmp   = (k == K_JAL) || (k == K_JALR);

    for (int i = 0; i <= iwait; i++) begin
      rdy = (i == iwait);
      imem_ready = rdy;
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      check("fetch_state", state, 3'd0);
      check("fetch_strobes", obs_vec(), {2'b01, rdy, 5'b0});
      @(negedge clk);
    end

    noise(); #1;
    check("decode_state", state, 3'd1);
    check("decode_strobes", obs_vec(), 8'h00);
    @(negedge clk);

    noise(); #1;
    check("exec_state", state, 3'd2);
    pce = (k == K_BR) || (k == K_NOP) || (k == K_ILL && !HALT_EN);
    check("exec_strobes", obs_vec(), {3'b000, pce, (k == K_BR) && bt, 3'b000});
    chk_sel = 1'b1;
    case (k)
      K_ALU:                     es = {2'b00, f7[5], f3};
      K_IMM:                     es = {2'b01, (f3 == 3'd5) && f7[5], f3};
      K_AUIPC, K_JAL, K_BR:      es = 6'b110000;
      K_JALR, K_LOAD, K_STORE:   es = 6'b010000;
      default: begin             es = 6'b000000; chk_sel = 1'b0; end
    endcase
    if (chk_sel) check("exec_sel", {alu_a_sel, alu_b_sel, alu_op}, es);
    @(negedge clk);

`ifdef CTRL_ILLEGAL_HALT_EN
    if (k == K_ILL) begin
      for (int i = 0; i < 3; i++) begin
        noise(); #1;
        check("halt_state", state, 3'd5);
        check("halt_strobes", obs_vec(), 8'h80);
        @(negedge clk);
      end
      #1;
      check("halt_instret", instret, model_instret);
      return;
    end
`endif

    if (mem_k) begin
      for (int i = 0; i <= dwait; i++) begin
        rdy = (i == dwait);
        dmem_ready = rdy;
        imem_ready = 1'($urandom_range(0, 1));
        #1;
        check("mem_state", state, 3'd3);
        check("mem_strobes", obs_vec(), {3'b000, st && rdy, 1'b0, 1'b1, st, 1'b0});
        check("mem_sel", {alu_a_sel, alu_b_sel, alu_op}, 6'b010000);
        @(negedge clk);
      end
    end

    if (wb_k) begin
      noise(); #1;
      check("wb_state", state, 3'd4);
      check("wb_strobes", obs_vec(), {3'b000, 1'b1, jmp, 2'b00, rdv != 5'd0});
      ewb = jmp ? 2'b10 : (k == K_LOAD) ? 2'b01 : (k == K_LUI) ? 2'b11 : 2'b00;
      check("wb_sel", wb_sel, ewb);
      @(negedge clk);
    end

    model_instret = model_instret + 32'd1;
    #1;
    check("instret", instret, model_instret);
    check("ret_state", state, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    kind_t k;
    reset = 1'b1; opcode = 7'd0; func3 = 3'd0; func7 = 7'd0; rd = 5'd0;
    branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    model_instret = 32'd0;

    // Reset: strobes stay low regardless of inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      noise(); opcode = 7'($urandom);
      #1;
      if (i > 0) begin
        check("rst_state", state, 3'd0);
        check("rst_instret", instret, 32'd0);
      end
      check("rst_strobes", obs_vec(), 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_instr(K_ALU,  3'd0, 7'h00, 5'd5, 1'b0, 0, 0);
    run_instr(K_ALU,  3'd0, 7'h20, 5'd6, 1'b0, 1, 0);
    run_instr(K_LOAD, 3'd2, 7'h00, 5'd7, 1'b0, 0, 2);
    run_instr(K_BR,   3'd0, 7'h00, 5'd0, 1'b1, 0, 0);
    run_instr(K_BR,   3'd0, 7'h00, 5'd0, 1'b0, 0, 0);
    run_instr(K_JAL,  3'd0, 7'h00, 5'd0, 1'b0, 0, 0);
    run_instr(K_STORE,3'd2, 7'h00, 5'd3, 1'b0, 0, 1);
    run_instr(K_IMM,  3'd5, 7'h20, 5'd9, 1'b0, 0, 0);
    run_instr(K_IMM,  3'd1, 7'h20, 5'd9, 1'b0, 0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      k = kind_t'($urandom_range(0, 9));
      run_instr(k, 3'($urandom), $urandom_range(0, 1) ? 7'h20 : 7'h00,
                5'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Unlisted opcode
    run_instr(K_ILL, 3'd0, 7'h00, 5'd1, 1'b0, 0, 0);
`ifdef CTRL_ILLEGAL_HALT_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_instret = 32'd0;
    #1;
    check("halt_exit_state", state, 3'd0);
    check("halt_exit_illegal", illegal, 1'b0);
`endif

    // Reset while a store waits in MEM
    opcode = op_of(K_STORE, 1'b0); rd = 5'd2;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rstmem_state", state, 3'd3);
    check("rstmem_req", dmem_req, 1'b1);
    @(negedge clk);
    reset = 1'b1; dmem_ready = 1'b1;
    #1;
    check("rstmem_strobes", obs_vec(), 8'h00);
    @(negedge clk);
    reset = 1'b0; dmem_ready = 1'b0;
    #1;
    check("rstmem_next_state", state, 3'd0);
    check("rstmem_instret", instret, 32'd0);
    check("rstmem_fetch_req", imem_req, 1'b1);
    model_instret = 32'd0;
    @(negedge clk);

    // Counter wrap
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    model_instret = 32'hFFFF_FFFF;
    check("preset_instret", instret, 32'hFFFF_FFFF);
    @(negedge clk);
    run_instr(K_NOP, 3'd0, 7'h00, 5'd0, 1'b0, 0, 0);
    check("wrap_instret", instret, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multi-cycle main control state machine for the RV32I fetch/decode datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. It drives the PC register enable, the PC next-value mux select (`pcjump`), the instruction-register load, ALU operand and operation selects, data-memory strobes and register-file write. It sits beside the fetch/decode top level and consumes the decoded `opcode`/`rd`/`func3`/`func7` fields.

## Interface
Parameters:
- `RESET_STATE`, 3'd0, encoding of FETCH; fixed, not to be overridden.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 7: decoded opcode from the held instruction register.
- `func3` input 3: decoded func3.
- `func7` input 7: decoded func7.
- `rd` input 5: destination register index.
- `branch_taken` input 1: comparator result for the current branch.
- `imem_ready` input 1: instruction memory data valid.
- `dmem_ready` input 1: data memory access complete.
- `imem_req` output 1: instruction fetch request.
- `ir_en` output 1: load instruction register.
- `pc_en` output 1: PC register update strobe.
- `pcjump` output 1: mux select; 1 = ALU result, 0 = PC+4.
- `alu_a_sel` output 1: 0 = rs1, 1 = PC.
- `alu_b_sel` output 1: 0 = rs2, 1 = immediate.
- `alu_op` output 4: {alt, func3}; 4'b0000 = ADD, 4'b1000 = SUB.
- `dmem_req` output 1: data memory request.
- `dmem_we` output 1: store when 1, valid with `dmem_req`.
- `reg_we` output 1: register-file write.
- `wb_sel` output 2: writeback source. 00 = ALU, 01 = load data, 10 = PC+4, 11 = immediate.
- `state` output 3: current state.
- `instret` output 32: retired-instruction counter.
- `illegal` output 1: illegal-opcode halt flag (see Configuration).

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: `imem_req`=1 until `imem_ready`. On ready: `ir_en`=1 for one cycle, then go to DECODE.
- DECODE: one cycle, then go to EXEC.
- EXEC, by opcode:
  - OP 0110011: `alu_op`={func7[5],func3}, b=rs2, then WB.
  - OP-IMM 0010011: b=imm, `alu_op`={func3==101 ? func7[5] : 0, func3}, then WB.
  - LUI 0110111: go to WB.
  - AUIPC 0010111: a=PC, b=imm, ADD, then WB.
  - JAL 1101111: a=PC, b=imm, ADD, then WB.
  - JALR 1100111: a=rs1, b=imm, ADD, then WB.
  - LOAD 0000011 / STORE 0100011: a=rs1, b=imm, ADD, then MEM.
  - BRANCH 1100011: a=PC, b=imm, ADD; `pc_en`=1, `pcjump`=`branch_taken`, then FETCH.
  - FENCE 0001111 / SYSTEM 1110011: NOP. `pc_en`=1, `pcjump`=0, then FETCH.
  - Any other opcode: see Configuration.
- MEM: `dmem_req`=1 held until `dmem_ready`; ALU selects held stable.
  - `dmem_we`=1 for STORE. On ready, STORE asserts `pc_en` and goes to FETCH.
  - LOAD goes to WB on ready.
- WB: `reg_we`=1 unless `rd`==0.
  - `wb_sel`: 10 for JAL/JALR, 01 for LOAD, 11 for LUI, 00 otherwise.
  - `pc_en`=1; `pcjump`=1 only for JAL/JALR (ALU result is held from EXEC). Then FETCH.
- `instret` increments by 1 on every cycle with `pc_en`=1 and wraps 0xFFFFFFFF to 0.
- All strobes are combinational from state and inputs. Strobes not listed for a state are 0.

## Timing
- Reset: `state`=FETCH and `instret`=0. While `reset`=1, every strobe and `illegal` is forced to 0.
- First `imem_req` is asserted in the first cycle after `reset` falls.
- Cycles per instruction with zero-wait memory (ready asserted in the same cycle as the request):
  - ALU, LUI, AUIPC, JAL, JALR: 4.
  - Load: 5.
  - Store: 4.
  - Branch, NOP: 3.
- Each cycle of `imem_ready`=0 or `dmem_ready`=0 adds one cycle. Outputs are held stable during wait states.
- Ready while no request is pending is ignored.
- Reset during any state abandons the instruction: no `pc_en`, no `reg_we`, `instret` is cleared.
- `pc_en` is asserted exactly once per retired instruction.

## Configuration
- `CTRL_ILLEGAL_HALT_EN` defined: an unlisted opcode in EXEC goes to HALT.
  - In HALT, `illegal`=1, all strobes are 0, and the state is left only by `reset`.
  - `instret` does not count the illegal instruction.
- `CTRL_ILLEGAL_HALT_EN` undefined: an unlisted opcode is a NOP (`pc_en`=1, `pcjump`=0, then FETCH). HALT is unreachable and `illegal` is tied to 0.

## Test plan
- Reset then `add` with zero-wait memory -> state sequence 0,1,2,4,0. `reg_we`=1 and `pc_en`=1 in cycle 4; `pcjump`=0; `instret`=1.
- `lw` with `dmem_ready` low for 2 cycles -> MEM held 3 cycles with `dmem_req`=1 and `dmem_we`=0; WB has `wb_sel`=01; total 7 cycles.
- `beq`, once with `branch_taken`=1 and once with 0 -> EXEC asserts `pc_en` with `pcjump`=1, then 0; no `reg_we`; 3 cycles each.
- `jal` with rd=0 -> WB has `reg_we`=0, `pcjump`=1, `wb_sel`=10.
- Opcode 7'b1111111 -> with the macro: HALT, `illegal`=1, `instret` unchanged. Without the macro: NOP, `instret` increments.
- Reset pulse during MEM of a store; separately, `instret` preset near wrap -> `dmem_req` drops, the next state is FETCH, `instret`=0; 0xFFFFFFFF retires to 0.
